// File: rtl/regfile_wb_param.sv
// Parametrised register file with byte-lane writes, N read ports and an in-order write-back buffer.
// Optional build macro WB_BYPASS_EN: read ports forward buffered data per byte lane.
module regfile_wb_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 3,
  parameter int NUM_RD   = 2,
  parameter int WB_DEPTH = 2,
  parameter int R0_ZERO  = 0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_RD*ADDR_W-1:0]        rd_addr,
  output logic [NUM_RD*DATA_W-1:0]        rd_data,
  input  logic                            wr_valid,
  output logic                            wr_ready,
  input  logic [ADDR_W-1:0]               wr_addr,
  input  logic [DATA_W-1:0]               wr_data_alu,
  input  logic [DATA_W-1:0]               wr_data_id,
  input  logic                            wr_data_sel,
  input  logic [DATA_W/8-1:0]             wr_byte_en,
  input  logic                            wb_hold,
  output logic [$clog2(WB_DEPTH+1)-1:0]   wb_count,
  output logic [2**ADDR_W-1:0]            pending
);

  localparam int NUM_REGS = 2**ADDR_W;
  localparam int NB       = DATA_W/8;
  localparam int CNT_W    = $clog2(WB_DEPTH+1);
  localparam int PTR_W    = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [NB-1:0]     be;
  } entry_t;

  entry_t              wb_q [WB_DEPTH];
  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [PTR_W-1:0]    head, tail;
  logic [CNT_W-1:0]    count;
  logic                accept, drain, r0_drop;
  entry_t              wr_entry, head_e;
  logic [DATA_W-1:0]   head_mask;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(WB_DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  // k-th oldest slot; head + k can exceed the pointer range when depth is not a power of two
  function automatic logic [PTR_W-1:0] slot(input logic [PTR_W-1:0] h, input int k);
    logic [PTR_W:0] s;
    s = {1'b0, h} + (PTR_W+1)'(k);
    if (s >= (PTR_W+1)'(WB_DEPTH)) s = s - (PTR_W+1)'(WB_DEPTH);
    return s[PTR_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] lane_mask(input logic [NB-1:0] be);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int l = 0; l < NB; l++) m[l*8 +: 8] = {8{be[l]}};
    return m;
  endfunction

  assign wb_count  = count;
  assign wr_ready  = (count < CNT_W'(WB_DEPTH));
  assign accept    = wr_valid && wr_ready;
  assign drain     = (count != '0) && !wb_hold;
  assign head_e    = wb_q[head];
  assign head_mask = lane_mask(head_e.be);
  assign r0_drop   = (R0_ZERO != 0) && (head_e.addr == '0);

  always_comb begin
    wr_entry.addr = wr_addr;
    wr_entry.data = wr_data_sel ? wr_data_id : wr_data_alu;
    wr_entry.be   = wr_byte_en;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      for (int i = 0; i < WB_DEPTH; i++) wb_q[i] <= '0;
    end else begin
      if (accept) begin
        wb_q[tail] <= wr_entry;
        tail       <= bump(tail);
      end
      if (drain) begin
        head <= bump(head);
        if (!r0_drop)
          regs[head_e.addr] <= (regs[head_e.addr] & ~head_mask) | (head_e.data & head_mask);
      end
      case ({accept, drain})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    pending = '0;
    for (int k = 0; k < WB_DEPTH; k++)
      if (CNT_W'(k) < count) pending[wb_q[slot(head, k)].addr] = 1'b1;
    if (R0_ZERO != 0) pending[0] = 1'b0;
  end

  always_comb begin : rd_mux
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rv;
    ra      = '0;
    rv      = '0;
    rd_data = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      ra = rd_addr[p*ADDR_W +: ADDR_W];
      rv = regs[ra];
`ifdef WB_BYPASS_EN
      // oldest to youngest, so the youngest enabled lane wins
      for (int k = 0; k < WB_DEPTH; k++) begin
        if ((CNT_W'(k) < count) && (wb_q[slot(head, k)].addr == ra)) begin
          for (int l = 0; l < NB; l++)
            if (wb_q[slot(head, k)].be[l]) rv[l*8 +: 8] = wb_q[slot(head, k)].data[l*8 +: 8];
        end
      end
`endif
      if ((R0_ZERO != 0) && (ra == '0)) rv = '0;
      rd_data[p*DATA_W +: DATA_W] = rv;
    end
  end

endmodule

// File: tb/tb_regfile_wb_param.sv
// Bench for regfile_wb_param: directed scenarios then random traffic against a queue-based model.
module tb_regfile_wb_param;

`ifdef WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  rd_addr;
  logic [63:0] rd_data, z_rd_data;
  logic        wr_valid, wr_ready, z_wr_ready;
  logic [2:0]  wr_addr;
  logic [31:0] wr_data_alu, wr_data_id;
  logic        wr_data_sel;
  logic [3:0]  wr_byte_en;
  logic        wb_hold;
  logic [1:0]  wb_count, z_wb_count;
  logic [7:0]  pending, z_pending;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [2:0]  a;
    logic [31:0] d;
    logic [3:0]  be;
  } ent_t;

  logic [31:0] m_regs [8];
  ent_t        m_q [$];

  always #10 clk = ~clk;

  regfile_wb_param dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data_alu(wr_data_alu), .wr_data_id(wr_data_id), .wr_data_sel(wr_data_sel),
    .wr_byte_en(wr_byte_en), .wb_hold(wb_hold), .wb_count(wb_count), .pending(pending)
  );

  regfile_wb_param #(.R0_ZERO(1)) u_z (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(z_rd_data),
    .wr_valid(wr_valid), .wr_ready(z_wr_ready), .wr_addr(wr_addr),
    .wr_data_alu(wr_data_alu), .wr_data_id(wr_data_id), .wr_data_sel(wr_data_sel),
    .wr_byte_en(wr_byte_en), .wb_hold(wb_hold), .wb_count(z_wb_count), .pending(z_pending)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] a);
    logic [31:0] v;
    v = m_regs[a];
    if (BYPASS)
      foreach (m_q[i])
        if (m_q[i].a == a)
          for (int l = 0; l < 4; l++)
            if (m_q[i].be[l]) v[l*8 +: 8] = m_q[i].d[l*8 +: 8];
    return v;
  endfunction

  function automatic logic [7:0] model_pending();
    logic [7:0] p;
    p = '0;
    foreach (m_q[i]) p[m_q[i].a] = 1'b1;
    return p;
  endfunction

  task automatic check_all();
    logic [5:0] saved;
    chk("wr_ready", {31'b0, wr_ready}, {31'b0, (m_q.size() < 2)});
    chk("wb_count", {30'b0, wb_count}, m_q.size());
    chk("pending", {24'b0, pending}, {24'b0, model_pending()});
    saved = rd_addr;
    for (int r = 0; r < 8; r += 2) begin
      rd_addr = {3'(r + 1), 3'(r)};
      #1;
      chk($sformatf("rd_r%0d", r), rd_data[31:0], model_read(3'(r)));
      chk($sformatf("rd_r%0d", r + 1), rd_data[63:32], model_read(3'(r + 1)));
    end
    rd_addr = saved;
  endtask

  task automatic cycle();
    bit   acc, drn;
    ent_t e, n;
    acc = wr_valid && (m_q.size() < 2);
    drn = (m_q.size() > 0) && !wb_hold;
    n.a = wr_addr;
    n.d = wr_data_sel ? wr_data_id : wr_data_alu;
    n.be = wr_byte_en;
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) m_regs[i] = '0;
      m_q.delete();
    end else begin
      if (drn) begin
        e = m_q.pop_front();
        for (int l = 0; l < 4; l++)
          if (e.be[l]) m_regs[e.a][l*8 +: 8] = e.d[l*8 +: 8];
      end
      if (acc) m_q.push_back(n);
    end
    #1;
    check_all();
  endtask

  task automatic set_wr(input logic [2:0] a, input logic [31:0] alu, input logic [31:0] id,
                        input logic sel, input logic [3:0] be);
    wr_valid = 1'b1; wr_addr = a; wr_data_alu = alu; wr_data_id = id;
    wr_data_sel = sel; wr_byte_en = be;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) m_regs[i] = 32'hDEAD_BEEF;
    rst_n = 1'b0; rd_addr = '0; wr_valid = 1'b0; wr_addr = '0;
    wr_data_alu = '0; wr_data_id = '0; wr_data_sel = 1'b0; wr_byte_en = '0; wb_hold = 1'b0;

    // reset
    cycle();
    chk("rst_z_ready", {31'b0, z_wr_ready}, 32'd1);
    chk("rst_z_count", {30'b0, z_wb_count}, 32'd0);
    rst_n = 1'b1;

    // MOV then MOVT merge
    set_wr(3'd0, 32'h0000_FFFF, 32'h0, 1'b0, 4'b1111);
    cycle();
    set_wr(3'd0, 32'h1234_5678, 32'hEEEE_0000, 1'b1, 4'b1100);
    cycle();
    wr_valid = 1'b0;
    cycle();
    cycle();
    rd_addr = 6'd0; #1;
    chk("merge_r0", rd_data[31:0], 32'hEEEE_FFFF);

    // backpressure under hold
    wb_hold = 1'b1;
    set_wr(3'd2, 32'h2222_2222, 32'h0, 1'b0, 4'b1111);
    cycle();
    set_wr(3'd3, 32'h3333_3333, 32'h0, 1'b0, 4'b1111);
    cycle();
    set_wr(3'd5, 32'h5555_5555, 32'h0, 1'b0, 4'b1111);
    chk("bp_ready_low", {31'b0, wr_ready}, 32'd0);
    chk("bp_count_full", {30'b0, wb_count}, 32'd2);
    cycle();
    wb_hold = 1'b0;
    cycle();
    chk("bp_first_drain", {30'b0, wb_count}, 32'd1);
    chk("bp_pend_r3", {24'b0, pending}, 32'h08);
    cycle();
    chk("bp_third_in", {30'b0, wb_count}, 32'd1);
    chk("bp_pend_r5", {24'b0, pending}, 32'h20);
    wr_valid = 1'b0;
    cycle();
    cycle();

    // held write visibility
    wb_hold = 1'b1;
    set_wr(3'd1, 32'h0000_0001, 32'h0, 1'b0, 4'b1111);
    cycle();
    wr_valid = 1'b0;
    rd_addr = 6'd1; #1;
    chk("hold_rd_r1", rd_data[31:0], BYPASS ? 32'h1 : 32'h0);
    chk("hold_pend_r1", {31'b0, pending[1]}, 32'd1);
    cycle();
    cycle();
    wb_hold = 1'b0;
    cycle();
    rd_addr = 6'd1; #1;
    chk("commit_rd_r1", rd_data[31:0], 32'h1);
    chk("commit_pend", {24'b0, pending}, 32'h0);

    // reset with two entries buffered
    wb_hold = 1'b1;
    set_wr(3'd3, 32'h0000_0033, 32'h0, 1'b0, 4'b1111);
    cycle();
    set_wr(3'd4, 32'h0000_0044, 32'h0, 1'b0, 4'b1111);
    cycle();
    wr_valid = 1'b0;
    chk("midrst_count", {30'b0, wb_count}, 32'd2);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    wb_hold = 1'b0;
    rd_addr = {3'd4, 3'd3}; #1;
    chk("midrst_r3", rd_data[31:0], 32'h0);
    chk("midrst_r4", rd_data[63:32], 32'h0);
    cycle();
    chk("midrst_r3_after", rd_data[31:0], 32'h0);

    // hardwired-zero R0 instance
    set_wr(3'd0, 32'hFFFF_FFFF, 32'h0, 1'b0, 4'b1111);
    chk("r0z_ready", {31'b0, z_wr_ready}, 32'd1);
    cycle();
    wr_valid = 1'b0;
    rd_addr = 6'd0; #1;
    chk("r0z_count", {30'b0, z_wb_count}, 32'd1);
    chk("r0z_pend0", {31'b0, z_pending[0]}, 32'd0);
    chk("r0z_rd", z_rd_data[31:0], 32'h0);
    cycle();
    rd_addr = 6'd0; #1;
    chk("r0z_rd_commit", z_rd_data[31:0], 32'h0);
    chk("r0_plain_rd", rd_data[31:0], 32'hFFFF_FFFF);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      wr_valid    = ($urandom_range(0, 3) != 0);
      wr_addr     = 3'($urandom_range(0, 7));
      wr_data_alu = $urandom;
      wr_data_id  = $urandom;
      wr_data_sel = 1'($urandom_range(0, 1));
      wr_byte_en  = 4'($urandom_range(0, 15));
      wb_hold     = ($urandom_range(0, 3) == 0);
      rst_n       = ($urandom_range(0, 99) != 0);
      rd_addr     = 6'($urandom_range(0, 63));
      cycle();
    end
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
